row_window_buff: RTL and testbench
==================================

# row_window_buff

Multi-row line buffer that turns a raster stream of pixel beats into a vertical window of `WIN_ROWS` column-aligned beats. It keeps `WIN_ROWS-1` previous rows in a ring of row memories. It sits between the pixel ingest stream and the 2-D filter datapath, one instance per filter. It adds valid/ready handshaking, frame tracking and optional top-edge replication to the single-row buffer generation.

## Interface
- `PIXELS_PER_BEAT`, 16, pixels per beat
- `PIXEL_WIDTH`, 8, bits per pixel
- `IMAGE_DIM`, 512, row width in pixels; must be a multiple of `PIXELS_PER_BEAT`
- `IMAGE_ROWS`, 512, rows per frame; must be ≥ `WIN_ROWS`
- `WIN_ROWS`, 3, window height; must be ≥ 2
- `DATA_WIDTH`, `PIXEL_WIDTH*PIXELS_PER_BEAT`, beat width (derived)

Ports:
- `clk` input 1: single clock, rising edge
- `aresetn` input 1: asynchronous, active-low reset
- `in_valid` input 1: input beat valid
- `in_ready` output 1: input beat accepted when `in_valid & in_ready`
- `in_data` input `DATA_WIDTH`: raster-order pixel beat
- `out_valid` output 1: window beat valid
- `out_ready` input 1: downstream accepts the window beat
- `out_data` output `WIN_ROWS*DATA_WIDTH`: window; oldest row in MSBs, current input row in LSBs
- `out_row_last` output 1: the window beat is the last column of a row
- `out_frame_last` output 1: the window beat is the last beat of a frame
- `frame_done` output 1: one-cycle pulse when the last input beat of a frame is accepted

## Operation
- Derived values:
  - `COLS = IMAGE_DIM/PIXELS_PER_BEAT`
  - column counter `col` is `$clog2(COLS)` bits
  - row counter `row` is `$clog2(IMAGE_ROWS)` bits
  - bank index `head` is `$clog2(WIN_ROWS-1)` bits (minimum 1)
- Storage: `WIN_ROWS-1` banks of `COLS` × `DATA_WIDTH`. Bank `head` holds the oldest stored row.
- On an accepted beat at (`row`, `col`):
  - all banks are read at `col` (read-before-write);
  - `in_data` is written to bank `head` at `col`;
  - `col` increments.
- At `col == COLS-1`: `col` wraps to 0, `head` advances modulo `WIN_ROWS-1`, and `row` increments.
- At `row == IMAGE_ROWS-1` with `col == COLS-1`: `row` wraps to 0, `frame_done` pulses, and the FSM returns to PRIME. `head` is not reset.
- Window ordering: tap k (k = 0 is oldest, k = `WIN_ROWS-2` is newest stored) comes from bank `(head + k) mod (WIN_ROWS-1)`. The final tap is `in_data`.
- FSM states:
  - PRIME (reset state, and after each frame): inputs are accepted. Window beats are emitted only under `BORDER_REPLICATE_EN`. Moves to RUN when the last beat of row `WIN_ROWS-2` is accepted.
  - RUN: every accepted beat produces one window beat. Moves to PRIME on frame wrap.
- Handshake: `in_ready = ~out_valid | out_ready` (combinational; single output register, no skid buffer). An accepted beat that produces no window in PRIME does not set `out_valid`.
- `out_row_last` and `out_frame_last` are registered alongside `out_data`.

## Timing
- Latency: a window beat appears on `out_data`/`out_valid` 1 cycle after its input beat is accepted.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- `out_valid`, `out_data`, `out_row_last` and `out_frame_last` hold stable while `out_valid & ~out_ready`.
- `out_valid` clears the cycle after handshake completion unless a new producing beat is accepted in that same cycle.
- Reset values:
  - `out_valid`, `out_data`, `out_row_last`, `out_frame_last` and `frame_done` are 0;
  - `in_ready` is 1;
  - counters and `head` are 0; state is PRIME.
- Bank contents are not reset.
- Reset asserted mid-frame: immediate abort. The partial frame is discarded and the next accepted beat is treated as (row 0, col 0).
- `in_valid` low mid-row: counters hold. Gaps are allowed anywhere.

## Configuration
- `BORDER_REPLICATE_EN` defined:
  - PRIME also emits a window beat per accepted input.
  - A tap of age a (a rows above the current row) that falls above row 0 is replaced by the row-0 value. Row 0 takes it from `in_data`; later rows take it from the bank holding row 0.
  - Output count per frame is `IMAGE_ROWS*COLS`.
- Not defined:
  - No output during PRIME.
  - Output count per frame is `(IMAGE_ROWS-WIN_ROWS+1)*COLS`; the first window is rows 0..`WIN_ROWS-1`.

## Test plan
Bench config: `IMAGE_DIM=64`, `PIXELS_PER_BEAT=16` (COLS=4), `WIN_ROWS=3`, `IMAGE_ROWS=4`. Beat value = `{row, col}` replicated per byte.

1. Stream 16 beats with `out_ready=1`, macro off → exactly 8 window beats. The first is rows {0,1,2} at col 0, one cycle after beat (2,0) is accepted. `out_row_last` is set on cols 3. `out_frame_last` is set on the 8th beat. `frame_done` pulses on beat (3,3).
2. Same stimulus, macro on → 16 window beats. Row 0 gives {0,0,0}, row 1 gives {0,0,1}, row 3 gives {1,2,3}.
3. Hold `out_ready=0` while in RUN → `in_ready` drops after one window is captured and `out_data` stays unchanged. Releasing `out_ready` gives back-to-back beats with no loss or duplication.
4. Random `in_valid` gaps plus random `out_ready` stalls over 3 consecutive frames → output matches the reference model. Window ordering stays correct across `head` rotation at each frame boundary.
5. Assert `aresetn` low for 1 cycle after beat (2,1) → all outputs are 0 within the reset cycle, then a fresh frame restarts at row 0 and its first window appears after row 2 col 0.
6. Simultaneous handshake: `out_valid=1`, `out_ready=1`, `in_valid=1` in RUN → a new window loads in the same cycle and `out_valid` stays high.

Source files
------------

// File: rtl/row_window_buff.sv
// row_window_buff
//   Multi-row line buffer. Turns a raster stream of pixel beats into a
//   vertical window of WIN_ROWS column-aligned beats. WIN_ROWS-1 previous
//   rows live in a ring of row banks. The live input row is always the
//   bottom tap.
//
//   Optional feature macro: BORDER_REPLICATE_EN
//     When it is defined, windows are also emitted while the first rows are
//     still priming. Rows above row 0 are filled with copies of row 0.
//
// Ports
//   clk            : single clock, rising edge
//   aresetn        : asynchronous active-low reset
//   in_valid       : input beat valid
//   in_ready       : input beat accepted when in_valid & in_ready
//   in_data        : raster-order pixel beat (DATA_WIDTH)
//   out_valid      : window beat valid
//   out_ready      : downstream accepts the window beat
//   out_data       : window (WIN_ROWS*DATA_WIDTH). The oldest row is in the
//                    MSBs and the current input row is in the LSBs.
//   out_row_last   : window beat is the last column of a row
//   out_frame_last : window beat is the last beat of a frame
//   frame_done     : one-cycle pulse after the last beat of a frame is accepted
module row_window_buff #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int PIXEL_WIDTH     = 8,
  parameter int IMAGE_DIM       = 512,
  parameter int IMAGE_ROWS      = 512,
  parameter int WIN_ROWS        = 3,
  parameter int DATA_WIDTH      = PIXEL_WIDTH * PIXELS_PER_BEAT
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIN_ROWS*DATA_WIDTH-1:0] out_data,
  output logic                           out_row_last,
  output logic                           out_frame_last,
  output logic                           frame_done
);

  localparam int COLS   = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int NB     = WIN_ROWS - 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = $clog2(IMAGE_ROWS);
  localparam int HEAD_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [0:0] PRIME = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic [HEAD_W-1:0]         head;
  logic [0:0]                state;
  logic                      accept;
  logic                      last_col;
  logic                      last_row;
  logic                      produce;
  logic [WIN_ROWS*DATA_WIDTH-1:0] window;
  logic [HEAD_W-1:0]         bank_sel;
  logic [DATA_WIDTH-1:0]     tap;

  logic [DATA_WIDTH-1:0]     mem [NB][COLS];

`ifdef BORDER_REPLICATE_EN
  logic [HEAD_W-1:0]         row0_bank;
`endif

  // Single output register with no skid buffer. A new beat may enter
  // whenever the held window is empty or is leaving this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign last_col = (col == COL_W'(COLS - 1));
  assign last_row = (row == ROW_W'(IMAGE_ROWS - 1));

`ifdef BORDER_REPLICATE_EN
  assign produce = accept;
`else
  assign produce = accept & (state == RUN);
`endif

  // Raster position, bank ring pointer and priming state. head always
  // names the bank with the oldest stored row, and that bank is the one
  // overwritten by the incoming row. head carries over across frames.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      col   <= '0;
      row   <= '0;
      head  <= '0;
      state <= PRIME;
    end else if (accept) begin
      if (last_col) begin
        col  <= '0;
        head <= (head == HEAD_W'(NB - 1)) ? '0 : head + 1'b1;
        if (last_row) begin
          row   <= '0;
          state <= PRIME;
        end else begin
          row <= row + 1'b1;
          if (row == ROW_W'(WIN_ROWS - 2)) begin
            state <= RUN;
          end
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef BORDER_REPLICATE_EN
  // Remember which bank row 0 of the current frame landed in. Taps that
  // would reach above the top edge copy that bank instead.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      row0_bank <= '0;
    end else if (accept && (row == '0)) begin
      row0_bank <= head;
    end
  end
`endif

  // Row banks are plain storage and are not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[head][col] <= in_data;
    end
  end

  // Window assembly. Reads use the bank contents from before this cycle's
  // write, so the oldest row is still visible while it is being replaced.
  always_comb begin
    window   = '0;
    bank_sel = '0;
    tap      = '0;
    for (int k = 0; k < NB; k++) begin
      if (int'(head) + k >= NB) begin
        bank_sel = HEAD_W'(int'(head) + k - NB);
      end else begin
        bank_sel = HEAD_W'(int'(head) + k);
      end
      tap = mem[bank_sel][col];
`ifdef BORDER_REPLICATE_EN
      // Tap k looks NB-k rows up. If that row is above the frame, use row 0.
      if (int'(row) < NB - k) begin
        tap = (row == '0) ? in_data : mem[row0_bank][col];
      end
`endif
      window[(WIN_ROWS-1-k)*DATA_WIDTH +: DATA_WIDTH] = tap;
    end
    window[DATA_WIDTH-1:0] = in_data;
  end

  // Output register. It holds while stalled, loads on every producing
  // accept (including one in the same cycle as a handshake), and drains
  // otherwise.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_row_last   <= 1'b0;
      out_frame_last <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= accept & last_col & last_row;
      if (produce) begin
        out_valid      <= 1'b1;
        out_data       <= window;
        out_row_last   <= last_col;
        out_frame_last <= last_col & last_row;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_row_window_buff.sv
// tb_row_window_buff
//   Self-checking bench for row_window_buff. It uses a small image:
//   4 columns of beats, 4 rows and a 3-row window. The reference model keeps
//   the whole current frame as an image array. Each expected window is
//   built by looking up rows r-2..r directly, clamped to row 0 when
//   BORDER_REPLICATE_EN is defined.
module tb_row_window_buff;

  localparam int PPB  = 16;
  localparam int PW   = 8;
  localparam int DIM  = 64;
  localparam int ROWS = 4;
  localparam int WR   = 3;
  localparam int COLS = DIM / PPB;
  localparam int DW   = PW * PPB;
  localparam int OW   = WR * DW;

`ifdef BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif
  localparam int WIN_PER_FRAME = BORDER ? ROWS * COLS : (ROWS - WR + 1) * COLS;

  typedef struct {
    logic [OW-1:0] data;
    logic          row_last;
    logic          frame_last;
    int            cyc;
  } win_t;

  logic          clk;
  logic          aresetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_row_last;
  logic          out_frame_last;
  logic          frame_done;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   ready_rand = 0;
  int   last_acc_cyc = 0;

  logic [DW-1:0] img [ROWS][COLS];
  int   mr = 0;
  int   mc = 0;
  win_t exp_q[$];
  win_t got_q[$];
  int   fd_q[$];

  row_window_buff #(
    .PIXELS_PER_BEAT(PPB),
    .PIXEL_WIDTH(PW),
    .IMAGE_DIM(DIM),
    .IMAGE_ROWS(ROWS),
    .WIN_ROWS(WR)
  ) dut (
    .clk(clk),
    .aresetn(aresetn),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_row_last(out_row_last),
    .out_frame_last(out_frame_last),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every window that leaves the DUT and every frame_done pulse.
  initial begin
    win_t w;
    forever begin
      @(negedge clk);
      if (aresetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        w.data       = out_data;
        w.row_last   = out_row_last;
        w.frame_last = out_frame_last;
        w.cyc        = cyc;
        got_q.push_back(w);
      end
      if (aresetn === 1'b1 && frame_done === 1'b1) fd_q.push_back(cyc);
    end
  end

  // Random downstream back-pressure, only active when ready_rand is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] pat(input int r, input int c);
    logic [7:0] b;
    b = {4'(r), 4'(c)};
    return {PPB{b}};
  endfunction

  // Reference model: store the beat in the frame image and emit the
  // window made of rows r-2, r-1 and r.
  task automatic model_accept(input logic [DW-1:0] d);
    win_t w;
    int   src;
    img[mr][mc] = d;
    if (BORDER || mr >= WR - 1) begin
      w.data = '0;
      for (int a = 0; a < WR; a++) begin
        src = mr - a;
        if (src < 0) src = 0;
        w.data[a*DW +: DW] = img[src][mc];
      end
      w.row_last   = (mc == COLS - 1);
      w.frame_last = (mc == COLS - 1) && (mr == ROWS - 1);
      w.cyc        = 0;
      exp_q.push_back(w);
    end
    if (mc == COLS - 1) begin
      mc = 0;
      mr = (mr == ROWS - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    bit ok;
    int budget;
    ok = 0;
    budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && budget < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1;
      else budget++;
    end
    last_acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) begin
      model_accept(d);
    end else begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL send_beat: in_ready stayed 0 for 200 cycles, required 1");
    end
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (got_q.size() < exp_q.size() && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (got_q.size() < exp_q.size()) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL drain: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_data  = '0;
    aresetn  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    mr = 0;
    mc = 0;
    exp_q.delete();
    got_q.delete();
    fd_q.delete();
  endtask

  task automatic test_reset();
    ready_rand = 0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    aresetn    = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset out_valid: got %b required 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset in_ready: got %b required 1", in_ready); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("[TB] FAIL reset out_data: got %h required 0", out_data); end
    n_cmp++; if (out_row_last !== 1'b0) begin n_err++; $display("[TB] FAIL reset out_row_last: got %b required 0", out_row_last); end
    n_cmp++; if (out_frame_last !== 1'b0) begin n_err++; $display("[TB] FAIL reset out_frame_last: got %b required 0", out_frame_last); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("[TB] FAIL reset frame_done: got %b required 0", frame_done); end
    apply_reset();
  endtask

  task automatic test_stream();
    int first_r, acc_first, acc_last, idx3;
    logic [OW-1:0] lit0, lit3, g0, g3;
    ready_rand = 0;
    out_ready  = 1'b1;
    apply_reset();
    first_r   = BORDER ? 0 : WR - 1;
    acc_first = -1;
    acc_last  = -1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        send_beat(pat(r, c));
        if (r == first_r && c == 0) acc_first = last_acc_cyc;
        if (r == ROWS - 1 && c == COLS - 1) acc_last = last_acc_cyc;
      end
    end
    wait_drain();
    n_cmp++;
    if (got_q.size() !== WIN_PER_FRAME) begin
      n_err++; $display("[TB] FAIL stream count: got %0d required %0d", got_q.size(), WIN_PER_FRAME);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].row_last !== exp_q[i].row_last ||
          got_q[i].frame_last !== exp_q[i].frame_last) begin
        n_err++;
        $display("[TB] FAIL stream win%0d: got %h rl%b fl%b required %h rl%b fl%b", i, got_q[i].data,
                 got_q[i].row_last, got_q[i].frame_last, exp_q[i].data, exp_q[i].row_last, exp_q[i].frame_last);
      end
    end
    lit0 = BORDER ? {3{pat(0, 0)}} : {pat(0, 0), pat(1, 0), pat(2, 0)};
    lit3 = {pat(1, 0), pat(2, 0), pat(3, 0)};
    idx3 = BORDER ? 3 * COLS : COLS;
    g0 = (got_q.size() > 0) ? got_q[0].data : 'x;
    g3 = (got_q.size() > idx3) ? got_q[idx3].data : 'x;
    n_cmp++; if (g0 !== lit0) begin n_err++; $display("[TB] FAIL stream first window: got %h required %h", g0, lit0); end
    n_cmp++; if (g3 !== lit3) begin n_err++; $display("[TB] FAIL stream row3 window: got %h required %h", g3, lit3); end
    n_cmp++;
    if (got_q.size() == 0 || got_q[0].cyc !== acc_first + 1) begin
      n_err++; $display("[TB] FAIL stream latency: first window cycle %0d required %0d",
                        (got_q.size() > 0) ? got_q[0].cyc : -1, acc_first + 1);
    end
    n_cmp++;
    if (fd_q.size() !== 1 || fd_q[0] !== acc_last + 1) begin
      n_err++; $display("[TB] FAIL stream frame_done: pulses %0d first at %0d required 1 at %0d",
                        fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1, acc_last + 1);
    end
  endtask

  task automatic test_stall();
    logic [OW-1:0] held;
    logic          held_rl;
    ready_rand = 0;
    out_ready  = 1'b1;
    apply_reset();
    for (int r = 0; r < WR - 1; r++)
      for (int c = 0; c < COLS; c++) send_beat(pat(r, c));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_beat(pat(WR - 1, 0));
    held    = exp_q[$].data;
    held_rl = exp_q[$].row_last;
    in_valid = 1'b1;
    in_data  = pat(WR - 1, 1);
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL stall in_ready: got %b required 0", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held || out_row_last !== held_rl) begin
        n_err++; $display("[TB] FAIL stall hold: got v%b %h rl%b required v1 %h rl%b", out_valid, out_data, out_row_last, held, held_rl);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 1; c < COLS; c++) send_beat(pat(WR - 1, c));
    for (int r = WR; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) send_beat(pat(r, c));
    wait_drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("[TB] FAIL stall count: got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].row_last !== exp_q[i].row_last ||
          got_q[i].frame_last !== exp_q[i].frame_last) begin
        n_err++; $display("[TB] FAIL stall win%0d: got %h required %h", i, got_q[i].data, exp_q[i].data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] prev;
    ready_rand = 0;
    out_ready  = 1'b1;
    apply_reset();
    for (int r = 0; r < WR - 1; r++)
      for (int c = 0; c < COLS; c++) send_beat(pat(r, c));
    prev = '0;
    in_valid = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      in_data = pat(WR - 1, c);
      @(negedge clk);
      if (c > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev) begin
          n_err++; $display("[TB] FAIL b2b col%0d: got v%b %h required v1 %h", c, out_valid, out_data, prev);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++; $display("[TB] FAIL b2b in_ready col%0d: got %b required 1", c, in_ready);
        end
      end
      @(posedge clk);
      #1;
      model_accept(pat(WR - 1, c));
      prev = exp_q[$].data;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== prev) begin
      n_err++; $display("[TB] FAIL b2b last: got v%b %h required v1 %h", out_valid, out_data, prev);
    end
    @(posedge clk);
    #1;
    for (int r = WR; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) send_beat(pat(r, c));
    wait_drain();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++; $display("[TB] FAIL b2b count: got %0d required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    ready_rand = 0;
    out_ready  = 1'b1;
    apply_reset();
    ready_rand = 1;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < ROWS * COLS; b++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        d = {$urandom, $urandom, $urandom, $urandom};
        send_beat(d);
      end
    end
    ready_rand = 0;
    out_ready  = 1'b1;
    wait_drain();
    n_cmp++;
    if (got_q.size() !== 3 * WIN_PER_FRAME) begin
      n_err++; $display("[TB] FAIL random count: got %0d required %0d", got_q.size(), 3 * WIN_PER_FRAME);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].row_last !== exp_q[i].row_last ||
          got_q[i].frame_last !== exp_q[i].frame_last) begin
        n_err++; $display("[TB] FAIL random win%0d: got %h required %h", i, got_q[i].data, exp_q[i].data);
      end
    end
    n_cmp++;
    if (fd_q.size() !== 3) begin
      n_err++; $display("[TB] FAIL random frame_done: got %0d pulses required 3", fd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int first_r, acc_first;
    ready_rand = 0;
    out_ready  = 1'b1;
    apply_reset();
    for (int r = 0; r < WR; r++)
      for (int c = 0; c < COLS; c++)
        if (r < WR - 1 || c < 2) send_beat(pat(r, c));
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_row_last !== 1'b0 || out_frame_last !== 1'b0 ||
        frame_done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("[TB] FAIL midreset outputs: got v%b rdy%b rl%b fl%b fd%b data %h required v0 rdy1 rl0 fl0 fd0 data 0",
                        out_valid, in_ready, out_row_last, out_frame_last, frame_done, out_data);
    end
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    mr = 0;
    mc = 0;
    exp_q.delete();
    got_q.delete();
    fd_q.delete();
    first_r   = BORDER ? 0 : WR - 1;
    acc_first = -1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        send_beat(pat(r, c) ^ {PPB{8'h80}});
        if (r == first_r && c == 0) acc_first = last_acc_cyc;
      end
    end
    wait_drain();
    n_cmp++;
    if (got_q.size() !== WIN_PER_FRAME) begin
      n_err++; $display("[TB] FAIL midreset count: got %0d required %0d", got_q.size(), WIN_PER_FRAME);
    end
    n_cmp++;
    if (got_q.size() == 0 || got_q[0].cyc !== acc_first + 1) begin
      n_err++; $display("[TB] FAIL midreset latency: first window cycle %0d required %0d",
                        (got_q.size() > 0) ? got_q[0].cyc : -1, acc_first + 1);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].row_last !== exp_q[i].row_last ||
          got_q[i].frame_last !== exp_q[i].frame_last) begin
        n_err++; $display("[TB] FAIL midreset win%0d: got %h required %h", i, got_q[i].data, exp_q[i].data);
      end
    end
  endtask

  initial begin
    aresetn   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    $display("[TB] row_window_buff bench, border replicate = %0d", BORDER);
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
